// File: rtl/uart_tx_if.sv
// Byte-level handshake and line signals between a UART transmitter and its client.
// The serializer takes the slave side.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    modport master (
        output tx_data,
        output tx_send,
        input  tx_busy,
        input  tx_done,
        input  tx
    );

    modport slave (
        input  tx_data,
        input  tx_send,
        output tx_busy,
        output tx_done,
        output tx
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART serializer: start bit, 8 data bits LSB first, one stop bit.
// The bit period is CLK_FREQ/BAUD clocks; every output is a register.
module uart_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input logic      clock,
    input logic      rst,
    uart_tx_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLKS_PER_BIT = CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_end;

    assign bit_end     = (baud_cnt == BAUD_LAST);
    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

    // tx is loaded with the level of the state being entered, so the pin
    // changes on the same edge as the state and never passes through logic.
    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.tx_send) begin
                        shreg    <= bus.tx_data;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Next bit is shreg[1]: the value after this shift.
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit; expected line levels are
// built from the byte being sent, framed as {stop, data, start}.
module tb_uart_tx;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_tx_if u_if ();

    uart_tx #(
        .CLK_FREQ(40),
        .BAUD    (10)
    ) dut (
        .clock(clk),
        .rst  (rst),
        .bus  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after a rising edge: outputs reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge. Walks 40 frame cycles, optionally
    // poking tx_send/tx_data mid-frame, then checks the tx_done idle cycle.
    task automatic check_frame(input logic [7:0] b, input string tag,
                               input int poke_cyc, input logic [7:0] poke_data,
                               input bit scramble);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            check($sformatf("%s_tx%0d", tag, i), {7'd0, u_if.tx}, {7'd0, fr[i/4]});
            check($sformatf("%s_busy%0d", tag, i), {7'd0, u_if.tx_busy}, 8'd1);
            check($sformatf("%s_done%0d", tag, i), {7'd0, u_if.tx_done}, 8'd0);
            if (i == poke_cyc) begin
                u_if.tx_send = 1'b1;
                u_if.tx_data = poke_data;
            end else if (i == poke_cyc + 1) begin
                u_if.tx_send = 1'b0;
            end
            if (scramble) u_if.tx_data = 8'($urandom);
            step();
        end
        check({tag, "_end_tx"}, {7'd0, u_if.tx}, 8'd1);
        check({tag, "_end_busy"}, {7'd0, u_if.tx_busy}, 8'd0);
        check({tag, "_end_done"}, {7'd0, u_if.tx_done}, 8'd1);
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("%s_tx%0d", tag, i), {7'd0, u_if.tx}, 8'd1);
            check($sformatf("%s_busy%0d", tag, i), {7'd0, u_if.tx_busy}, 8'd0);
            check($sformatf("%s_done%0d", tag, i), {7'd0, u_if.tx_done}, 8'd0);
        end
    endtask

    task automatic send(input logic [7:0] b);
        u_if.tx_data = b;
        u_if.tx_send = 1'b1;
        step();
        u_if.tx_send = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        u_if.tx_send = 1'b1;
        u_if.tx_data = 8'hAA;

        // Reset held two cycles with tx_send asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("rst_tx%0d", i), {7'd0, u_if.tx}, 8'd1);
            check($sformatf("rst_busy%0d", i), {7'd0, u_if.tx_busy}, 8'd0);
            check($sformatf("rst_done%0d", i), {7'd0, u_if.tx_done}, 8'd0);
        end
        rst = 1'b0;
        step();
        u_if.tx_send = 1'b0;
        check_frame(8'hAA, "post_rst", -10, 8'h00, 1'b0);
        check_idle("post_rst_idle", 3);

        // Single byte.
        send(8'hA5);
        check_frame(8'hA5, "a5", -10, 8'h00, 1'b0);
        check_idle("a5_idle", 3);

        // Request during a frame is dropped, not queued.
        send(8'h3C);
        check_frame(8'h3C, "ign", 15, 8'hFF, 1'b0);
        check_idle("ign_idle", 6);

        // Back-to-back with tx_send held high.
        u_if.tx_data = 8'h00;
        u_if.tx_send = 1'b1;
        step();
        u_if.tx_data = 8'hFF;
        check_frame(8'h00, "b2b0", -10, 8'h00, 1'b0);
        step();
        u_if.tx_send = 1'b0;
        check_frame(8'hFF, "b2b1", -10, 8'h00, 1'b0);
        check_idle("b2b_idle", 3);

        // Reset mid-frame abandons the frame without a done pulse.
        send(8'h55);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("mid_tx%0d", i), {7'd0, u_if.tx}, {7'd0, (i < 4) ? 1'b0 : ((i / 4) % 2 == 1)});
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_tx", {7'd0, u_if.tx}, 8'd1);
        check("mid_rst_busy", {7'd0, u_if.tx_busy}, 8'd0);
        check("mid_rst_done", {7'd0, u_if.tx_done}, 8'd0);
        check_idle("mid_idle", 45);
        send(8'h81);
        check_frame(8'h81, "x81", -10, 8'h00, 1'b0);
        check_idle("x81_idle", 2);

        // tx_data churn during a frame does not reach the line.
        send(8'h0F);
        check_frame(8'h0F, "hold", -10, 8'h00, 1'b1);
        check_idle("hold_idle", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
